// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and the decode control unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } mem_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Opcodes decoded by cu; listed here so both blocks agree on encodings.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline status in, stage enables/flushes and data-memory handshake out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             ex_memRead;
    logic [4:0]       ex_rt;
    logic             ex_br_taken;
    logic             mem_memRead;
    logic             mem_memWrite;
    logic             dmem_ack;

    logic             dmem_req;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             memwb_bubble;
    logic             busy_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_jump, ex_memRead, ex_rt,
               ex_br_taken, mem_memRead, mem_memWrite, dmem_ack,
        input  dmem_req, pc_write, ifid_write, ifid_flush, idex_write,
               idex_flush, exmem_write, memwb_bubble, busy_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_jump, ex_memRead, ex_rt,
               ex_br_taken, mem_memRead, mem_memWrite, dmem_ack,
        output dmem_req, pc_write, ifid_write, ifid_flush, idex_write,
               idex_flush, exmem_write, memwb_bubble, busy_err, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a lw in EX whose rt is read by the instruction in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_memRead,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_uses_rt && (ex_rt == id_rt);

    // $0 is hardwired, so a lw targeting it never produces a value to wait for.
    assign load_use = ex_memRead && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: data-memory req/ack FSM with timeout, hazard priority mux,
// and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    // wait_cnt only has to reach TIMEOUT-2 (the last WAIT cycle before ERR).
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 2);

    mem_state_t       state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
    logic [CNT_W-1:0]  stall_cnt;
    logic              mem_acc;
    logic              mem_stall;
    logic              req_raw;
    logic              load_use;

    assign mem_acc = bus.mem_memRead | bus.mem_memWrite;

    hazard_detect u_hazard_detect (
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rt (bus.id_uses_rt),
        .ex_memRead (bus.ex_memRead),
        .ex_rt      (bus.ex_rt),
        .load_use   (load_use)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (!bus.pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        mem_stall   = 1'b0;
        req_raw     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_acc) begin
                    req_raw     = 1'b1;
                    mem_stall   = 1'b1;
                    wait_cnt_nx = '0;
                    state_nx    = WAIT;
                end
            end
            WAIT: begin
                req_raw   = 1'b1;
                mem_stall = 1'b1;
                if (bus.dmem_ack)
                    state_nx = DONE;
                else if (wait_cnt == WAIT_LAST)
                    state_nx = ERR;
                else
                    wait_cnt_nx = wait_cnt + 1'b1;
            end
            DONE: begin
                state_nx = IDLE;
            end
            ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Priority: reset, memory freeze, branch, load-use, jump, free-run.
    always_comb begin
        bus.pc_write     = 1'b1;
        bus.ifid_write   = 1'b1;
        bus.ifid_flush   = 1'b0;
        bus.idex_write   = 1'b1;
        bus.idex_flush   = 1'b0;
        bus.exmem_write  = 1'b1;
        bus.memwb_bubble = 1'b0;
        bus.dmem_req     = req_raw & ~rst;
        if (rst) begin
            bus.pc_write     = 1'b0;
            bus.ifid_write   = 1'b0;
            bus.idex_write   = 1'b0;
            bus.exmem_write  = 1'b0;
            bus.ifid_flush   = 1'b1;
            bus.idex_flush   = 1'b1;
            bus.memwb_bubble = 1'b1;
        end else if (mem_stall) begin
            bus.pc_write     = 1'b0;
            bus.ifid_write   = 1'b0;
            bus.idex_write   = 1'b0;
            bus.exmem_write  = 1'b0;
            bus.memwb_bubble = 1'b1;
        end else if (bus.ex_br_taken) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else if (load_use) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.idex_flush = 1'b1;
        end else if (bus.id_jump) begin
            bus.ifid_flush = 1'b1;
        end
    end

    assign bus.busy_err  = (state == ERR);
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, memory handshake, timeout, reset, counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 5;

    // Control vector order: {dmem_req, pc_write, ifid_write, ifid_flush,
    //                        idex_write, idex_flush, exmem_write, memwb_bubble}
    localparam logic [7:0] C_RST    = 8'b0001_0101;
    localparam logic [7:0] C_RUN    = 8'b0110_1010;
    localparam logic [7:0] C_LU     = 8'b0000_1110;
    localparam logic [7:0] C_BR     = 8'b0111_1110;
    localparam logic [7:0] C_JMP    = 8'b0111_1010;
    localparam logic [7:0] C_MEMSTL = 8'b1000_0001;
    localparam logic [7:0] C_FROZEN = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ctrl();
        return {bus.dmem_req, bus.pc_write, bus.ifid_write, bus.ifid_flush,
                bus.idex_write, bus.idex_flush, bus.exmem_write, bus.memwb_bubble};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks run 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rt   = 1'b0;
        bus.id_jump      = 1'b0;
        bus.ex_memRead   = 1'b0;
        bus.ex_rt        = 5'd0;
        bus.ex_br_taken  = 1'b0;
        bus.mem_memRead  = 1'b0;
        bus.mem_memWrite = 1'b0;
        bus.dmem_ack     = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        settle();
        check("rst_ctrl", 32'(ctrl()), 32'(C_RST));
        tick();
        rst = 1'b0;
        settle();
        check("post_rst_ctrl", 32'(ctrl()), 32'(C_RUN));
        check("post_rst_cnt", 32'(bus.stall_cnt), 32'd0);
        check("post_rst_err", 32'(bus.busy_err), 32'd0);

        // lw $2 in EX, ID reads rs=$2
        bus.ex_memRead = 1'b1; bus.ex_rt = 5'd2; bus.id_rs = 5'd2;
        settle();
        check("lu_rs_ctrl", 32'(ctrl()), 32'(C_LU));
        tick();
        clear_inputs();
        settle();
        check("lu_rs_after_ctrl", 32'(ctrl()), 32'(C_RUN));
        check("lu_rs_cnt", 32'(bus.stall_cnt), 32'd1);

        // rt match counts only when ID actually reads rt
        bus.ex_memRead = 1'b1; bus.ex_rt = 5'd3; bus.id_rs = 5'd7; bus.id_rt = 5'd3;
        bus.id_uses_rt = 1'b0;
        settle();
        check("rt_unused_ctrl", 32'(ctrl()), 32'(C_RUN));
        bus.id_uses_rt = 1'b1;
        settle();
        check("lu_rt_ctrl", 32'(ctrl()), 32'(C_LU));
        tick();
        clear_inputs();
        settle();
        check("lu_rt_cnt", 32'(bus.stall_cnt), 32'd2);

        // lw $0 never stalls
        bus.ex_memRead = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        bus.id_uses_rt = 1'b1;
        settle();
        check("zero_reg_ctrl", 32'(ctrl()), 32'(C_RUN));
        tick();
        clear_inputs();
        settle();
        check("zero_reg_cnt", 32'(bus.stall_cnt), 32'd2);

        // Branch beats load-use and jump
        bus.ex_br_taken = 1'b1; bus.ex_memRead = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
        bus.id_jump = 1'b1;
        settle();
        check("br_prio_ctrl", 32'(ctrl()), 32'(C_BR));
        tick();
        check("br_prio_cnt", 32'(bus.stall_cnt), 32'd2);

        // Load-use beats jump; jump follows next cycle
        bus.ex_br_taken = 1'b0;
        settle();
        check("lu_over_jmp_ctrl", 32'(ctrl()), 32'(C_LU));
        tick();
        bus.ex_memRead = 1'b0;
        settle();
        check("jmp_ctrl", 32'(ctrl()), 32'(C_JMP));
        check("jmp_cnt", 32'(bus.stall_cnt), 32'd3);
        tick();
        clear_inputs();

        // sw in MEM, ack on 3rd WAIT cycle; branch pending in EX is held off until DONE
        bus.mem_memWrite = 1'b1; bus.ex_br_taken = 1'b1;
        settle();
        check("sw_idle_ctrl", 32'(ctrl()), 32'(C_MEMSTL));
        tick();
        check("sw_wait1_ctrl", 32'(ctrl()), 32'(C_MEMSTL));
        tick();
        check("sw_wait2_ctrl", 32'(ctrl()), 32'(C_MEMSTL));
        tick();
        bus.dmem_ack = 1'b1;
        settle();
        check("sw_wait3_ctrl", 32'(ctrl()), 32'(C_MEMSTL));
        tick();
        bus.dmem_ack = 1'b0;
        settle();
        check("sw_done_ctrl", 32'(ctrl()), 32'(C_BR));
        check("sw_done_cnt", 32'(bus.stall_cnt), 32'd7);
        tick();
        clear_inputs();
        settle();
        check("sw_idle_after_ctrl", 32'(ctrl()), 32'(C_RUN));
        check("sw_idle_after_cnt", 32'(bus.stall_cnt), 32'd7);

        // Reset while in WAIT
        bus.mem_memRead = 1'b1;
        tick();
        check("rstwait_req", 32'(bus.dmem_req), 32'd1);
        rst = 1'b1;
        settle();
        check("rstwait_ctrl", 32'(ctrl()), 32'(C_RST));
        tick();
        rst = 1'b0;
        bus.mem_memRead = 1'b0;
        settle();
        check("rstwait_after_ctrl", 32'(ctrl()), 32'(C_RUN));
        check("rstwait_after_cnt", 32'(bus.stall_cnt), 32'd0);
        check("rstwait_after_err", 32'(bus.busy_err), 32'd0);

        // Ack on the last permitted WAIT cycle still completes
        bus.mem_memRead = 1'b1;
        settle();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        bus.dmem_ack = 1'b1;
        settle();
        check("late_ack_wait_ctrl", 32'(ctrl()), 32'(C_MEMSTL));
        tick();
        bus.dmem_ack = 1'b0;
        settle();
        check("late_ack_done_ctrl", 32'(ctrl()), 32'(C_RUN));
        check("late_ack_err", 32'(bus.busy_err), 32'd0);
        check("late_ack_cnt", 32'(bus.stall_cnt), 32'd8);
        tick();
        clear_inputs();
        tick();

        // lw in MEM, no ack: ERR after TIMEOUT stall cycles
        bus.mem_memRead = 1'b1;
        settle();
        for (int i = 0; i < TIMEOUT; i++) begin
            check($sformatf("to_wait%0d_req", i), 32'(bus.dmem_req), 32'd1);
            check($sformatf("to_wait%0d_err", i), 32'(bus.busy_err), 32'd0);
            tick();
        end
        check("to_err_ctrl", 32'(ctrl()), 32'(C_FROZEN));
        check("to_err_flag", 32'(bus.busy_err), 32'd1);
        check("to_err_cnt", 32'(bus.stall_cnt), 32'd16);

        // ERR is sticky: late ack, branch and a drained MEM stage change nothing
        bus.dmem_ack = 1'b1; bus.mem_memRead = 1'b0; bus.ex_br_taken = 1'b1;
        settle();
        for (int i = 0; i < 15; i++) tick();
        check("err_sticky_ctrl", 32'(ctrl()), 32'(C_FROZEN));
        check("err_sticky_flag", 32'(bus.busy_err), 32'd1);
        check("cnt_sat_hit", 32'(bus.stall_cnt), 32'd31);
        for (int i = 0; i < 5; i++) tick();
        check("cnt_sat_hold", 32'(bus.stall_cnt), 32'd31);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        settle();
        check("err_clear_flag", 32'(bus.busy_err), 32'd0);
        check("err_clear_ctrl", 32'(ctrl()), 32'(C_RUN));
        check("err_clear_cnt", 32'(bus.stall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
